// File: rtl/gray_cnt_sched_if.sv
// gray_cnt_sched_if: request/grant bundle for the shared Gray counter scheduler.
//   req    : request vector, bit i = requester i
//   len    : packed burst lengths, field i = len[i*LENW +: LENW]
//   gnt    : one-hot grant while a burst is running
//   busy   : scheduler is running or finishing a burst
//   done   : one-cycle pulse on the finishing requester's bit
//   gray_c : registered Gray code of the shared counter
//   zero   : shared counter is zero (held low during reset)
//   wrap   : one-cycle pulse after the counter rolls over to zero
// master = requester side, slave = scheduler side.
interface gray_cnt_sched_if #(
   parameter int unsigned CBITS = 9,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned LENW  = 4
);
   logic [NREQ-1:0]      req;
   logic [NREQ*LENW-1:0] len;
   logic [NREQ-1:0]      gnt;
   logic                 busy;
   logic [NREQ-1:0]      done;
   logic [CBITS-1:0]     gray_c;
   logic                 zero;
   logic                 wrap;

   modport master (
      output req, len,
      input  gnt, busy, done, gray_c, zero, wrap
   );

   modport slave (
      input  req, len,
      output gnt, busy, done, gray_c, zero, wrap
   );
endinterface

// File: rtl/gray_cnt_sched.sv
// gray_cnt_sched: round-robin scheduler sharing one Gray-coded counter among NREQ requesters.
// A granted requester advances the counter once per cycle for len[w] cycles, then gets a
// one-cycle done pulse. Counter and Gray code persist across bursts.
//   clk : clock, state updates on posedge
//   rst : asynchronous, active-high reset
//   bus : gray_cnt_sched_if.slave (req/len in; gnt/busy/done/gray_c/zero/wrap out)
module gray_cnt_sched #(
   parameter int unsigned CBITS = 9,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned LENW  = 4
) (
   input logic               clk,
   input logic               rst,
   gray_cnt_sched_if.slave   bus
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [CBITS-1:0] cnt_q, cnt_d;
   logic [CBITS-1:0] gray_q, gray_d;
   logic [LENW-1:0]  rem_q, rem_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    win_q, win_d;
   logic             wrap_q, wrap_d;

   logic [IW-1:0]    pick;
   logic             pick_vld;
   logic [LENW-1:0]  pick_len;
   int unsigned      idx;

   // Round-robin search starting at ptr_q; first set request wins.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      idx      = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = (int'(ptr_q) + i) % NREQ;
         if (!pick_vld && bus.req[idx]) begin
            pick_vld = 1'b1;
            pick     = IW'(idx);
         end
      end
   end

   assign pick_len = bus.len[pick*LENW +: LENW];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gray_d  = gray_q;
      rem_d   = rem_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      wrap_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pick_vld) begin
               win_d   = pick;
               rem_d   = pick_len;
               // Zero-length bursts skip RUN and go straight to the done pulse.
               state_d = (pick_len != '0) ? StRun : StDone;
            end
         end
         StRun: begin
            cnt_d  = cnt_q + 1'b1;
            // Gray code is registered alongside cnt so both change on the same edge.
            gray_d = cnt_d ^ (cnt_d >> 1);
            wrap_d = &cnt_q;
            rem_d  = rem_q - 1'b1;
            if (rem_q == LENW'(1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         gray_q  <= '0;
         rem_q   <= '0;
         ptr_q   <= '0;
         win_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gray_q  <= gray_d;
         rem_q   <= rem_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      bus.gnt  = '0;
      bus.done = '0;
      if (state_q == StRun) begin
         bus.gnt[win_q] = 1'b1;
      end
      if (state_q == StDone) begin
         bus.done[win_q] = 1'b1;
      end
   end

   assign bus.busy   = (state_q != StIdle);
   assign bus.gray_c = gray_q;
   assign bus.zero   = (cnt_q == '0) & ~rst;
   assign bus.wrap   = wrap_q;

endmodule

// File: doc/gray_cnt_sched.md
Name: gray_cnt_sched

Overview:
Round-robin scheduler that shares one free-running Gray-coded counter among NREQ requesters. A granted requester owns the counter for a burst of len[i] increment steps, then receives a one-cycle done pulse. The counter value and Gray code persist across bursts. The block fronts the team's Gray counter datapath wherever several agents must advance a common Gray sequence without interleaving.

Parameters:
CBITS, 9, width of the binary counter and of gray_c
NREQ, 4, number of requesters (>=2)
LENW, 4, width of each per-requester burst-length field

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous, active-high reset
req  input  NREQ  request vector, bit i = requester i
len  input  NREQ*LENW  burst lengths; field i = len[i*LENW +: LENW], steps requested
gnt  output  NREQ  one-hot grant, all-zero when not in RUN
busy  output  1  high in RUN or DONE
done  output  NREQ  one-cycle pulse on bit of finishing requester
gray_c  output  CBITS  Gray code of internal counter, = cnt ^ (cnt >> 1) at all times
zero  output  1  (cnt == 0) & ~rst
wrap  output  1  one-cycle pulse, registered, after an increment from all-ones to 0

Behaviour:
- Reset (async, immediate): state=IDLE, cnt=0, gray_c=0, gnt=0, done=0, busy=0, wrap=0, rem=0, rr pointer ptr=0. zero forced 0 while rst high, 1 the cycle after release.
- Reset mid-burst: burst aborted, no done pulse, cnt returns to 0.
- gray_c registered together with cnt. Never one cycle stale, never combinational from cnt.
- FSM states: IDLE, RUN, DONE.
- IDLE: if req==0 stay. Else pick winner w = first set bit searching ptr, ptr+1, ... mod NREQ. Capture rem=len[w]. Next state RUN if len[w]!=0, else DONE. gnt=onehot(w) from the next edge (RUN only).
- RUN: each cycle cnt<=cnt+1 (mod 2^CBITS), rem<=rem-1. When rem==1 at the edge, next state DONE. gnt held one-hot for exactly len[w] cycles.
- DONE: gnt=0, done[w]=1 for this cycle only. ptr<=(w+1) mod NREQ. Next state IDLE.
- Burst of L>0 occupies L+2 cycles (IDLE-decision, L×RUN, DONE). L=0 occupies 2 cycles (no RUN, no increment).
- req and len sampled only in IDLE. Changes during RUN/DONE ignored; deasserting req mid-burst does not shorten it.
- Simultaneous requests: rr order only. A requester holding req is granted within NREQ bursts (no starvation).
- cnt frozen outside RUN.
- Wrap: increment from 2^CBITS-1 to 0 gives wrap=1 the following cycle (coincident with cnt==0, zero=1). Wrap may fall mid-burst; the burst continues.
- Single-bit property: consecutive distinct gray_c values differ in exactly one bit, including across the wrap.
- done and gnt never high in the same cycle. At most one gnt bit and one done bit high.

Test Plan:
- Reset then req=4'b0001, len0=3 -> gnt=0001 for 3 cycles, gray_c 0->1->3->2, done=0001 one cycle later, busy high 4 cycles.
- req=4'b1111 held, all len=1 -> grants in order 0,1,2,3,0, each burst 3 cycles; done pulses follow the same order.
- Preload cnt to 510 via bursts (CBITS=9), then burst len=3 -> cnt 511,0,1; gray_c 0x100,0x000,0x001; wrap pulses once while cnt==0; zero=1 that cycle.
- len2=0 with req=4'b0100 -> no gnt, gray_c unchanged, done=0100 one cycle after the IDLE decision, ptr advances to 3.
- Assert rst during RUN with rem=5 -> gnt, busy, gray_c drop to 0 immediately; no done; after release the first grant goes to the lowest requesting index from ptr=0.
- Random req/len for 10k cycles -> assertions: gnt one-hot0, one-bit Gray steps, no starvation within NREQ bursts, eventually zero and eventually !zero after reset release.
